// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared types and defaults for the parametrised register file.
//   rf_state_t    : sequencer state (RF_CLEAR sweeping, RF_RUN normal use)
//   XLEN_DEFAULT  : default data width
//   NREGS_DEFAULT : default architectural register count
//   rf_aw(n)      : address width needed to index n registers
// ---------------------------------------------------------------------------
package reg_file_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/reg_clear_seq.sv
// ---------------------------------------------------------------------------
// reg_clear_seq
// Clear sequencer for the register file. After reset, or on a clr_req pulse
// while running, it sweeps every entry to zero one per cycle, then raises
// ready.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   clr_req  in   request a full clear (honoured only in RUN)
//   ready    out  1 = array valid, writes accepted
//   clr_we   out  array write strobe for the sweep
//   clr_addr out  array entry being cleared
// ---------------------------------------------------------------------------
module reg_clear_seq
  import reg_file_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = rf_aw(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  rf_state_t     state, state_next;
  logic [AW-1:0] ptr, ptr_next;
  logic          ready_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RF_CLEAR;
      ptr   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      ready <= ready_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    ready_next = ready;
    case (state)
      RF_CLEAR: begin
        if (ptr == LAST) begin
          state_next = RF_RUN;
          ready_next = 1'b1;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      RF_RUN: begin
        if (clr_req) begin
          state_next = RF_CLEAR;
          ptr_next   = '0;
          ready_next = 1'b0;
        end
      end
      default: begin
        state_next = RF_CLEAR;
        ptr_next   = '0;
        ready_next = 1'b0;
      end
    endcase
  end

  // The reset edge itself must not write the array.
  assign clr_we   = (state == RF_CLEAR) && !rst;
  assign clr_addr = ptr;

endmodule

// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
// Parametrised 2-read/1-write register file for the decode stage. Optional
// write-to-read bypass and hard-wired zero register. Contents are cleared by
// reg_clear_seq after reset or on clr_req; reads return 0 while clearing.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   we3      in   write enable
//   a3       in   write address
//   wd3      in   write data
//   a1, a2   in   read addresses
//   clr_req  in   request full clear (single-cycle pulse)
//   rd1, rd2 out  combinational read data
//   ready    out  1 = array valid, writes accepted
// ---------------------------------------------------------------------------
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEFAULT,
  parameter  int NREGS    = NREGS_DEFAULT,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = rf_aw(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we3,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] wd3,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  input  logic            clr_req,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            ready
);

  logic [XLEN-1:0] mem [NREGS];

  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          a1_ok, a2_ok, a3_ok;
  logic          wr_en;

  reg_clear_seq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .ready    (ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Address range check; with a power-of-two count every address is valid.
  if (NREGS == (1 << AW)) begin : g_full_range
    assign a1_ok = 1'b1;
    assign a2_ok = 1'b1;
    assign a3_ok = 1'b1;
  end else begin : g_part_range
    assign a1_ok = a1 < AW'(NREGS);
    assign a2_ok = a2 < AW'(NREGS);
    assign a3_ok = a3 < AW'(NREGS);
  end

  // Effective write: running, not being reset or cleared, valid target.
  assign wr_en = ready && !rst && we3 && !clr_req && a3_ok &&
                 !((ZERO_REG != 0) && (a3 == '0));

  // NOTE: the array has no reset branch; clearing is done one entry per cycle
  // by the sequencer so the storage can map onto plain RAM/flop arrays.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      mem[a3] <= wd3;
    end
  end

  always_comb begin
    rd1 = '0;
    if (ready && a1_ok && !((ZERO_REG != 0) && (a1 == '0))) begin
      if ((BYPASS != 0) && wr_en && (a3 == a1)) rd1 = wd3;
      else                                       rd1 = mem[a1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (ready && a2_ok && !((ZERO_REG != 0) && (a2 == '0))) begin
      if ((BYPASS != 0) && wr_en && (a3 == a2)) rd2 = wd3;
      else                                       rd2 = mem[a2];
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
// Four register-file instances share one stimulus stream:
//   0: defaults (NREGS=32, bypass, zero reg)
//   1: BYPASS=0
//   2: ZERO_REG=0
//   3: NREGS=20
// A behavioural model (plain arrays plus a sweep countdown) predicts ready
// and both read ports of every instance.
// ---------------------------------------------------------------------------
module tb_reg_file_param;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst, we3, clr_req;
  logic [4:0]  a1, a2, a3;
  logic [31:0] wd3;

  logic [31:0] rd1_o   [NI];
  logic [31:0] rd2_o   [NI];
  logic        ready_o [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    reg_file_param #(
      .XLEN     (32),
      .NREGS    ((g == 3) ? 20 : 32),
      .BYPASS   ((g == 1) ? 0 : 1),
      .ZERO_REG ((g == 2) ? 0 : 1)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .we3     (we3),
      .a3      (a3),
      .wd3     (wd3),
      .a1      (a1),
      .a2      (a2),
      .clr_req (clr_req),
      .rd1     (rd1_o[g]),
      .rd2     (rd2_o[g]),
      .ready   (ready_o[g])
    );
  end

  // ---------------- reference model ----------------
  function automatic int nr(input int k); return (k == 3) ? 20 : 32; endfunction
  function automatic bit by(input int k); return k != 1; endfunction
  function automatic bit zr(input int k); return k != 2; endfunction

  logic [31:0] m_mem  [NI][64];
  bit          m_rdy  [NI];
  int          m_left [NI];

  function automatic bit m_wr(input int k);
    return m_rdy[k] && !rst && we3 && !clr_req && (int'(a3) < nr(k)) &&
           !(zr(k) && a3 == 5'd0);
  endfunction

  function automatic logic [31:0] m_rd(input int k, input logic [4:0] a);
    if (!m_rdy[k] || int'(a) >= nr(k)) return 32'd0;
    if (zr(k) && a == 5'd0) return 32'd0;
    if (by(k) && m_wr(k) && a3 == a) return wd3;
    return m_mem[k][a];
  endfunction

  // Sweep is modelled as a countdown of edges; the array is zeroed when the
  // countdown expires (writes are ignored throughout, so timing is moot).
  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_rdy[k]  = 1'b0;
        m_left[k] = nr(k);
      end else if (!m_rdy[k]) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_rdy[k] = 1'b1;
          for (int i = 0; i < 64; i++) m_mem[k][i] = 32'd0;
        end
      end else if (clr_req) begin
        m_rdy[k]  = 1'b0;
        m_left[k] = nr(k);
      end else if (m_wr(k)) begin
        m_mem[k][a3] = wd3;
      end
    end
  endtask

  // Model updates on the same edge as the DUT; inputs change only after the
  // following falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int first [NI];
    rst = 1'b1; we3 = 1'b0; clr_req = 1'b0;
    a1 = 5'd5; a2 = 5'd0; a3 = 5'd0; wd3 = 32'd0;
    tick(); tick();
    #1;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (ready_o[k] !== 1'b0 || rd1_o[k] !== 32'd0 || rd2_o[k] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: ready=%b rd1=%h rd2=%h, required 0/0/0",
                 k, ready_o[k], rd1_o[k], rd2_o[k]);
      end
      first[k] = -1;
    end
    rst = 1'b0;
    for (int e = 0; e < 40; e++) begin
      we3 = (e < 19); a3 = 5'd5; wd3 = 32'hDEAD;
      a1 = 5'd5; a2 = 5'($urandom_range(0, 31));
      #1;
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (ready_o[k] !== m_rdy[k] || rd1_o[k] !== m_rd(k, a1) || rd2_o[k] !== m_rd(k, a2)) begin
          n_fail++;
          $display("FAIL reset_sweep[%0d] e=%0d: ready=%b rd1=%h rd2=%h, required %b %h %h",
                   k, e, ready_o[k], rd1_o[k], rd2_o[k], m_rdy[k], m_rd(k, a1), m_rd(k, a2));
        end
      end
      tick();
      for (int k = 0; k < NI; k++)
        if (ready_o[k] === 1'b1 && first[k] < 0) first[k] = e + 1;
    end
    we3 = 1'b0; a1 = 5'd5;
    #1;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (first[k] != nr(k)) begin
        n_fail++;
        $display("FAIL reset_len[%0d]: ready rose after %0d edges, required %0d", k, first[k], nr(k));
      end
      n_checks++;
      if (rd1_o[k] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_drop[%0d]: rd1=%h, required 0", k, rd1_o[k]);
      end
    end
  endtask

  task automatic test_run_bypass();
    logic [31:0] exp;
    we3 = 1'b1; a3 = 5'd7; wd3 = 32'h12345678; a1 = 5'd7; a2 = 5'd3;
    #1;
    for (int k = 0; k < NI; k++) begin
      exp = (k == 1) ? 32'd0 : 32'h12345678;
      n_checks++;
      if (rd1_o[k] !== exp || rd2_o[k] !== m_rd(k, a2)) begin
        n_fail++;
        $display("FAIL bypass_same[%0d]: rd1=%h rd2=%h, required %h %h",
                 k, rd1_o[k], rd2_o[k], exp, m_rd(k, a2));
      end
    end
    tick();
    we3 = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (rd1_o[k] !== 32'h12345678) begin
        n_fail++;
        $display("FAIL bypass_next[%0d]: rd1=%h, required 12345678", k, rd1_o[k]);
      end
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] exp;
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFFFFFF; a1 = 5'd0; a2 = 5'd0;
    for (int c = 0; c < 2; c++) begin
      #1;
      for (int k = 0; k < NI; k++) begin
        exp = (k == 2) ? 32'hFFFFFFFF : 32'd0;
        n_checks++;
        if (rd1_o[k] !== exp || rd2_o[k] !== exp) begin
          n_fail++;
          $display("FAIL zero_reg[%0d] c=%0d: rd1=%h rd2=%h, required %h",
                   k, c, rd1_o[k], rd2_o[k], exp);
        end
      end
      tick();
      we3 = 1'b0;
    end
  endtask

  task automatic test_random();
    int guard;
    for (int c = 0; c < 300; c++) begin
      clr_req = ($urandom_range(0, 99) == 0);
      we3     = 1'($urandom_range(0, 1));
      a3      = 5'($urandom_range(0, 31));
      wd3     = $urandom;
      a1      = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      a2      = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      #1;
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (ready_o[k] !== m_rdy[k] || rd1_o[k] !== m_rd(k, a1) || rd2_o[k] !== m_rd(k, a2)) begin
          n_fail++;
          $display("FAIL random[%0d] c=%0d: ready=%b rd1=%h rd2=%h, required %b %h %h",
                   k, c, ready_o[k], rd1_o[k], rd2_o[k], m_rdy[k], m_rd(k, a1), m_rd(k, a2));
        end
      end
      tick();
    end
    clr_req = 1'b0; we3 = 1'b0;
    guard = 0;
    while (!(ready_o[0] === 1'b1 && ready_o[1] === 1'b1 && ready_o[2] === 1'b1 &&
             ready_o[3] === 1'b1) && guard < 64) begin
      tick();
      guard++;
    end
    n_checks++;
    if (guard >= 64) begin
      n_fail++;
      $display("FAIL random_drain: ready not seen within 64 edges, required within 32");
    end
  endtask

  task automatic test_clear();
    int first [NI];
    for (int r = 1; r <= 3; r++) begin
      we3 = 1'b1; a3 = 5'(r); wd3 = 32'(11 * r);
      tick();
    end
    clr_req = 1'b1; we3 = 1'b1; a3 = 5'd4; wd3 = 32'd44;
    tick();
    clr_req = 1'b0; we3 = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (ready_o[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_start[%0d]: ready=%b, required 0", k, ready_o[k]);
      end
      first[k] = -1;
    end
    for (int e = 0; e < 40; e++) begin
      clr_req = (e == 5);
      we3 = (e < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
      a3  = 5'($urandom_range(0, 31));
      wd3 = $urandom;
      a1  = 5'($urandom_range(0, 31));
      a2  = a3;
      #1;
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (ready_o[k] !== m_rdy[k] || rd1_o[k] !== m_rd(k, a1) || rd2_o[k] !== m_rd(k, a2)) begin
          n_fail++;
          $display("FAIL clear_sweep[%0d] e=%0d: ready=%b rd1=%h rd2=%h, required %b %h %h",
                   k, e, ready_o[k], rd1_o[k], rd2_o[k], m_rdy[k], m_rd(k, a1), m_rd(k, a2));
        end
      end
      tick();
      for (int k = 0; k < NI; k++)
        if (ready_o[k] === 1'b1 && first[k] < 0) first[k] = e + 1;
    end
    clr_req = 1'b0; we3 = 1'b0;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (first[k] != nr(k)) begin
        n_fail++;
        $display("FAIL clear_len[%0d]: ready rose after %0d edges, required %0d", k, first[k], nr(k));
      end
    end
    for (int r = 1; r <= 4; r++) begin
      a1 = 5'(r); a2 = 5'(r);
      #1;
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (rd1_o[k] !== 32'd0 || rd2_o[k] !== 32'd0) begin
          n_fail++;
          $display("FAIL clear_read[%0d] r=%0d: rd1=%h rd2=%h, required 0", k, r, rd1_o[k], rd2_o[k]);
        end
      end
    end
  endtask

  task automatic test_mid_rst();
    int first [NI];
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int e = 0; e < 10; e++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NI; k++) first[k] = -1;
    for (int e = 0; e < 40; e++) begin
      a1 = 5'($urandom_range(0, 31)); a2 = 5'($urandom_range(0, 31));
      #1;
      for (int k = 0; k < NI; k++) begin
        n_checks++;
        if (ready_o[k] !== m_rdy[k] || rd1_o[k] !== m_rd(k, a1)) begin
          n_fail++;
          $display("FAIL midrst_sweep[%0d] e=%0d: ready=%b rd1=%h, required %b %h",
                   k, e, ready_o[k], rd1_o[k], m_rdy[k], m_rd(k, a1));
        end
      end
      tick();
      for (int k = 0; k < NI; k++)
        if (ready_o[k] === 1'b1 && first[k] < 0) first[k] = e + 1;
    end
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (first[k] != nr(k)) begin
        n_fail++;
        $display("FAIL midrst_len[%0d]: ready rose after %0d edges, required %0d", k, first[k], nr(k));
      end
    end
  endtask

  task automatic test_nregs20();
    we3 = 1'b1; a3 = 5'd25; wd3 = 32'hCAFE0001; a1 = 5'd25; a2 = 5'd25;
    #1;
    n_checks++;
    if (rd1_o[3] !== 32'd0 || rd2_o[3] !== 32'd0) begin
      n_fail++;
      $display("FAIL n20_oor_same: rd1=%h rd2=%h, required 0", rd1_o[3], rd2_o[3]);
    end
    n_checks++;
    if (rd1_o[0] !== 32'hCAFE0001) begin
      n_fail++;
      $display("FAIL n32_a25_bypass: rd1=%h, required cafe0001", rd1_o[0]);
    end
    tick();
    we3 = 1'b0;
    #1;
    n_checks++;
    if (rd1_o[3] !== 32'd0) begin
      n_fail++;
      $display("FAIL n20_oor_next: rd1=%h, required 0", rd1_o[3]);
    end
    we3 = 1'b1; a3 = 5'd19; wd3 = 32'hABCD; a1 = 5'd19; a2 = 5'd19;
    #1;
    n_checks++;
    if (rd1_o[3] !== 32'hABCD || rd2_o[3] !== 32'hABCD) begin
      n_fail++;
      $display("FAIL n20_top_bypass: rd1=%h rd2=%h, required 0000abcd", rd1_o[3], rd2_o[3]);
    end
    tick();
    we3 = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (rd1_o[k] !== m_rd(k, a1) || rd2_o[k] !== m_rd(k, a2)) begin
        n_fail++;
        $display("FAIL n20_after[%0d]: rd1=%h rd2=%h, required %h", k, rd1_o[k], rd2_o[k], m_rd(k, a1));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      m_rdy[k]  = 1'b0;
      m_left[k] = nr(k);
    end
    test_reset();
    test_run_bypass();
    test_zero_reg();
    test_random();
    test_clear();
    test_mid_rst();
    test_nregs20();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
